// File: rtl/peripheral_sync_filter_bb.sv
// rtl/peripheral_sync_filter_bb.sv - multi-channel pin synchronizer, glitch filter and edge detector
module peripheral_sync_filter_bb #(
    parameter int                 WIDTH     = 8,
    parameter int                 STAGES    = 2,
    parameter int                 FILTER_W  = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      data_in,
    input  logic [WIDTH-1:0]      filter_en,
    input  logic [FILTER_W-1:0]   filter_len,
    output logic [WIDTH-1:0]      data_out,
    output logic [WIDTH-1:0]      rise,
    output logic [WIDTH-1:0]      fall,
    output logic                  any_edge
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("peripheral_sync_filter_bb: STAGES must be at least 2");
        end
    endgenerate

    logic [STAGES-1:0][WIDTH-1:0]   sync_q, sync_d;
    logic [WIDTH-1:0]               sync;
    logic [WIDTH-1:0]               stable_q, stable_d;
    logic [WIDTH-1:0][FILTER_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]               rise_q, rise_d;
    logic [WIDTH-1:0]               fall_q, fall_d;
    logic                           any_edge_q, any_edge_d;

    // Synchronizer chain: stage 0 samples the pins, each later stage copies the one before.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], data_in};
    end

    assign sync = sync_q[STAGES-1];

    // Per-channel filter: a new level is accepted once the mismatch has outlasted the threshold.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!filter_en[i] || (filter_len == '0)) begin
                stable_d[i] = sync[i];
            end else if (sync[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= filter_len) begin
                // >= rather than == so a lowered threshold still releases a long-running count.
                stable_d[i] = sync[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + FILTER_W'(1);
            end
        end
    end

    // Edge pulses line up with the first cycle data_out shows the new level.
    always_comb begin
        rise_d     = ~stable_q & stable_d;
        fall_d     = stable_q & ~stable_d;
        any_edge_d = |(rise_d | fall_d);
    end

    // State registers; reset loads RESET_VAL so release never manufactures an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= {STAGES{RESET_VAL}};
            stable_q   <= RESET_VAL;
            cnt_q      <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            any_edge_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            any_edge_q <= any_edge_d;
        end
    end

    assign data_out = stable_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign any_edge = any_edge_q;

endmodule

// File: tb/tb_peripheral_sync_filter_bb.sv
// tb/tb_peripheral_sync_filter_bb.sv - self-checking bench for peripheral_sync_filter_bb
module tb_peripheral_sync_filter_bb;

    localparam int          WIDTH  = 8;
    localparam int          STAGES = 2;
    localparam int          FW     = 4;
    localparam logic [7:0]  RV     = 8'hA5;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       data_in;
    logic [7:0]       filter_en;
    logic [FW-1:0]    filter_len;
    logic [7:0]       data_out;
    logic [7:0]       rise;
    logic [7:0]       fall;
    logic             any_edge;

    int checks = 0;
    int errors = 0;

    // Reference model: pin history, accepted level, and length of the current mismatch run.
    logic [7:0] hist[$];
    logic [7:0] m_out, m_rise, m_fall;
    logic       m_any;
    int         m_run[8];

    bit         pat[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int         first_edge;

    peripheral_sync_filter_bb #(
        .WIDTH(WIDTH), .STAGES(STAGES), .FILTER_W(FW), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .filter_en(filter_en),
        .filter_len(filter_len), .data_out(data_out), .rise(rise),
        .fall(fall), .any_edge(any_edge)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < STAGES; k++) hist.push_back(RV);
        m_out  = RV;
        m_rise = '0;
        m_fall = '0;
        m_any  = 1'b0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
    endtask

    // One clock edge of the rules: the level seen STAGES samples ago is compared with the output.
    task automatic model_step();
        logic [7:0] s;
        logic [7:0] nxt;
        int         len;
        s   = hist[STAGES-1];
        nxt = m_out;
        len = int'(filter_len);
        for (int i = 0; i < 8; i++) begin
            if (!filter_en[i] || len == 0) begin
                nxt[i]   = s[i];
                m_run[i] = 0;
            end else if (s[i] == m_out[i]) begin
                m_run[i] = 0;
            end else if (m_run[i] >= len) begin
                nxt[i]   = s[i];
                m_run[i] = 0;
            end else begin
                m_run[i] = m_run[i] + 1;
            end
        end
        m_rise = ~m_out & nxt;
        m_fall = m_out & ~nxt;
        m_any  = (m_rise | m_fall) != 8'h00;
        m_out  = nxt;
        hist.push_front(data_in);
        void'(hist.pop_back());
    endtask

    task automatic compare_all();
        check8("data_out", data_out, m_out);
        check8("rise", rise, m_rise);
        check8("fall", fall, m_fall);
        check1("any_edge", any_edge, m_any);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        data_in    = 8'($urandom);
        filter_en  = '0;
        filter_len = '0;
        model_reset();
        #3;

        // Reset holds RESET_VAL whatever the pins do.
        for (int k = 0; k < 5; k++) begin
            data_in = 8'($urandom);
            tick();
            check8("rst_data_out", data_out, RV);
            check8("rst_pulses", rise | fall, 8'h00);
            check1("rst_any_edge", any_edge, 1'b0);
        end

        // Release with pins equal to RESET_VAL: no pulses.
        data_in = RV;
        rst     = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check1("release_no_any_edge", any_edge, 1'b0);
            check8("release_no_pulses", rise | fall, 8'h00);
        end

        // Unfiltered path on channel 0.
        data_in[0] = 1'b0;
        repeat (5) tick();
        data_in[0] = 1'b1;
        tick();
        tick();
        check1("unf_e2_out0", data_out[0], 1'b0);
        tick();
        check1("unf_e3_out0", data_out[0], 1'b1);
        check1("unf_e3_rise0", rise[0], 1'b1);
        tick();
        check1("unf_e4_rise0", rise[0], 1'b0);
        data_in[0] = 1'b0;
        tick();
        tick();
        check1("unf_e2_fall0", fall[0], 1'b0);
        tick();
        check1("unf_e3_fall0", fall[0], 1'b1);
        tick();
        check1("unf_e4_fall0", fall[0], 1'b0);

        // Glitch rejection on channel 1, L=3.
        filter_en[1] = 1'b1;
        filter_len   = 4'd3;
        repeat (4) tick();
        data_in[1] = 1'b1;
        repeat (3) tick();
        data_in[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check1("glitch_out1", data_out[1], 1'b0);
            check1("glitch_rise1", rise[1], 1'b0);
        end
        data_in[1] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) check1("filt_e5_out1", data_out[1], 1'b0);
        end
        check1("filt_e6_out1", data_out[1], 1'b1);
        check1("filt_e6_rise1", rise[1], 1'b1);
        tick();
        check1("filt_e7_rise1", rise[1], 1'b0);

        // Bouncing input on channel 3.
        filter_en[3] = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 9; k++) begin
            data_in[3] = (k < 7) ? pat[k] : 1'b1;
            tick();
            if (k + 1 == 8) check1("bounce_e8_out3", data_out[3], 1'b0);
        end
        check1("bounce_e9_out3", data_out[3], 1'b1);
        check1("bounce_e9_rise3", rise[3], 1'b1);

        // Threshold lowered below a running count on channel 4.
        filter_en[4] = 1'b1;
        filter_len   = 4'd7;
        repeat (3) tick();
        data_in[4] = 1'b1;
        repeat (7) tick();
        check1("thr_e7_out4", data_out[4], 1'b0);
        filter_len = 4'd2;
        tick();
        check1("thr_e8_out4", data_out[4], 1'b1);
        check1("thr_e8_rise4", rise[4], 1'b1);

        // Filter disabled mid-count on channel 6.
        filter_len   = 4'd7;
        filter_en[6] = 1'b1;
        repeat (3) tick();
        data_in[6] = 1'b1;
        repeat (5) tick();
        check1("dis_e5_out6", data_out[6], 1'b0);
        filter_en[6] = 1'b0;
        tick();
        check1("dis_e6_out6", data_out[6], 1'b1);
        check1("dis_e6_rise6", rise[6], 1'b1);

        // All channels rise together.
        filter_en = '0;
        data_in   = 8'h00;
        repeat (5) tick();
        data_in = 8'hFF;
        tick();
        tick();
        check1("multi_e2_any", any_edge, 1'b0);
        tick();
        check8("multi_e3_rise", rise, 8'hFF);
        check1("multi_e3_any", any_edge, 1'b1);
        tick();
        check1("multi_e4_any", any_edge, 1'b0);

        // Reset while channel 1 is part-way through its count.
        data_in = RV;
        repeat (5) tick();
        filter_en  = 8'h02;
        filter_len = 4'd3;
        data_in    = RV | 8'h02;
        repeat (4) tick();
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        check8("midrst_out", data_out, RV);
        tick();
        rst        = 1'b0;
        first_edge = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (data_out[1] && first_edge == 0) first_edge = e;
        end
        checki("midrst_relatency", first_edge, STAGES + 1 + 3);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if (k % 37 == 0) begin
                filter_en  = 8'($urandom);
                filter_len = FW'($urandom_range(0, 5));
            end
            data_in = data_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                compare_all();
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/peripheral_sync_filter_bb.md
# peripheral_sync_filter_bb

Multi-channel input conditioner for the BlackBone GPIO peripheral. Each of `WIDTH` asynchronous pins passes through a `STAGES`-deep synchronizer, an optional per-channel glitch filter with run-time threshold, and a rise/fall edge detector. It sits between the GPIO pads and the GPIO register/interrupt logic. It replaces the fixed 1-bit, 2-stage synchronizer cell on input paths.

## Interface
Parameters:
- `WIDTH`, default 8: number of channels.
- `STAGES`, default 2: synchronizer flops per channel. Legal values are 2 or more; anything less is an elaboration error.
- `FILTER_W`, default 4: width of the filter threshold and of each channel's counter.
- `RESET_VAL`, default 0 (`WIDTH` bits): reset value of every synchronizer flop and of `data_out`.

Ports:
- `clk`, input, 1: receiving clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `data_in`, input, `WIDTH`: asynchronous pin inputs.
- `filter_en`, input, `WIDTH`: per-channel filter enable. Synchronous to `clk`.
- `filter_len`, input, `FILTER_W`: filter threshold L, shared by all channels. Synchronous to `clk`.
- `data_out`, output, `WIDTH`: filtered, synchronized level.
- `rise`, output, `WIDTH`: 1-cycle pulse when `data_out[i]` goes 0 to 1.
- `fall`, output, `WIDTH`: 1-cycle pulse when `data_out[i]` goes 1 to 0.
- `any_edge`, output, 1: OR of all bits of `rise` and `fall`, registered alongside them.

## Operation
- **Synchronizer, per channel i:** a chain `s[0..STAGES-1]`, with `s[0] <= data_in[i]` and `s[k] <= s[k-1]`. `sync[i] = s[STAGES-1]`. There is no combinational path from `data_in`.
- **Stable register, per channel:** `stable[i]` drives `data_out[i]`. The channel also has a counter `cnt[i]` of `FILTER_W` bits.
- **Filter disabled (`filter_en[i]=0`) or L=0:**
  - `stable[i] <= sync[i]` every cycle.
  - `cnt[i] <= 0`.
- **Filter enabled and L>0:**
  - If `sync[i] == stable[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] >= L`: `stable[i] <= sync[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i] + 1`.
  - Net effect: a change is accepted only after L+1 consecutive cycles of mismatch. Any shorter pulse is discarded and leaves `data_out` unchanged.
- **Threshold compare:** uses `>=`. If `filter_len` is lowered below a running count, the update happens on the next mismatch cycle. The counter never wraps, because it is cleared when it reaches L and L is at most 2^FILTER_W-1.
- **Enable toggling:** changing `filter_en[i]` mid-count takes effect on the next edge.
  - Enabled to disabled: `stable` follows `sync` immediately and `cnt` clears.
  - Disabled to enabled: counting starts from 0.
- **Edge detect:** registered at the same edge as the `stable` update.
  - `rise[i] <= ~stable[i] & next_stable[i]`.
  - `fall[i] <= stable[i] & ~next_stable[i]`.
  - `any_edge <= |(rise_next | fall_next)`.
  - Pulses are high during the first cycle in which `data_out` shows the new value.
- **Reset (async assert, sync to clk release by the system):**
  - All `s` flops and `stable` take `RESET_VAL`.
  - `cnt`, `rise`, `fall` and `any_edge` go to 0.
  - No edge pulse is generated by reset or its release. If a pin differs from `RESET_VAL` after release, it produces a normal, delayed edge.
- **Reset mid-filter:** the partial count is lost and the channel restarts as after power-up.
- **Channel independence:** channels are fully independent. Simultaneous edges on several channels produce simultaneous pulses and a single-cycle `any_edge`.

## Timing
- Clock edges are counted from the first edge that samples a new `data_in` level (edge 1).
- **Unfiltered latency:** `sync` changes at edge `STAGES`, and `data_out` and the pulse change at edge `STAGES+1`. With default parameters that is edge 3.
- **Filtered latency:** `data_out` changes at edge `STAGES+1+L`. With defaults and L=3 that is edge 6.
- **Rejected glitches:** a mismatch lasting at most L cycles at `sync` produces no change on any output.
- **Pulse width:** exactly 1 cycle. Back-to-back opposite edges are possible only when the filter is off or L=0.
- All outputs are flop outputs. There are no combinational input-to-output paths.

## Test plan
- **Reset values:** `RESET_VAL=8'hA5` with `rst` held high and random `data_in` -> `data_out=8'hA5`; `rise`, `fall` and `any_edge` are 0. After release with `data_in=8'hA5`, there are no pulses for 20 cycles.
- **Unfiltered path:** `filter_en=0`, `STAGES=2`, `data_in[0]` 0->1 before edge 1 -> `data_out[0]=1` and `rise[0]=1` at edge 3 only. Then `data_in[0]` 1->0 -> `fall[0]` pulses 1 cycle, 3 edges later.
- **Glitch rejection:** `filter_en[1]=1`, L=3, `data_in[1]` high for 3 cycles -> `data_out[1]` stays 0 with no pulse. Holding it high for 4 or more cycles -> `data_out[1]=1` at edge 6, and `rise[1]` pulses once.
- **Bouncing input:** same setup, pattern 1,1,0,1,1,1,1 -> the counter restarts on the 0, and `data_out` rises 4 cycles after the final run of 1s begins at `sync`.
- **Threshold and enable change mid-count:** L=7, `cnt` reaches 5, then L is set to 2 -> update on the next edge. Separately, disabling the filter mid-count -> `data_out` follows on the next edge.
- **Multi-channel and reset mid-operation:** toggling all 8 channels together -> 8 rise bits in the same cycle and a single `any_edge` pulse. Asserting `rst` at `cnt=2` -> outputs go to `RESET_VAL` and `cnt` to 0, and a later mismatch needs the full L+1 cycles again.
